pktgen_drr_sched: RTL and testbench

Deficit-round-robin scheduler that shares the single packet-generation datapath between `NUM_QUEUES` per-flow tuple queues. Each queue presents a head five-tuple plus packet length with a valid/ready handshake. The block grants heads in byte-weighted proportion to per-queue quanta and emits one registered tuple stream, tagged with the source queue id, toward the packet builder.

---
 rtl/pktgen_sched_pkg.sv | 41 ++++
 rtl/drr_deficit_bank.sv | 44 ++++
 rtl/pktgen_drr_sched.sv | 149 ++++++++++++++
 tb/tb_pktgen_drr_sched.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pktgen_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pktgen_sched_pkg : shared types and helpers for the DRR tuple scheduler     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package pktgen_sched_pkg;

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OUT   = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    DEF_NOP = 2'd0,
    DEF_ADD = 2'd1,
    DEF_SUB = 2'd2,
    DEF_CLR = 2'd3
  } def_op_t;

  localparam int MIN_PKT_LEN = 60;
  localparam int SAT_W       = 32;

  // Clamp at 2^width-1; width must stay below SAT_W.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      width);
    logic [SAT_W:0]   sum;
    logic [SAT_W-1:0] maxv;
    maxv = (SAT_W'(1) << width) - SAT_W'(1);
    sum  = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, maxv}) ? maxv : sum[SAT_W-1:0];
  endfunction

  function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/drr_deficit_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | drr_deficit_bank : per-queue saturating deficit counters, one op per cycle  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module drr_deficit_bank
  import pktgen_sched_pkg::*;
#(
  parameter int NUM_QUEUES    = 4,
  parameter int DEFICIT_WIDTH = 18,
  parameter int QID_WIDTH     = $clog2(NUM_QUEUES)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [QID_WIDTH-1:0]     i_idx,
  input  def_op_t                  i_op,
  input  logic [DEFICIT_WIDTH-1:0] i_operand,
  output logic [DEFICIT_WIDTH-1:0] o_deficit
);

  logic [DEFICIT_WIDTH-1:0] r_deficit [NUM_QUEUES];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_QUEUES; k++) begin
        r_deficit[k] <= '0;
      end
    end else begin
      case (i_op)
        DEF_ADD: r_deficit[i_idx] <= DEFICIT_WIDTH'(sat_add(SAT_W'(r_deficit[i_idx]),
                                                            SAT_W'(i_operand),
                                                            DEFICIT_WIDTH));
        DEF_SUB: r_deficit[i_idx] <= DEFICIT_WIDTH'(sat_sub(SAT_W'(r_deficit[i_idx]),
                                                            SAT_W'(i_operand)));
        DEF_CLR: r_deficit[i_idx] <= '0;
        default: ;
      endcase
    end
  end

  assign o_deficit = r_deficit[i_idx];

endmodule
`default_nettype wire

// File: rtl/pktgen_drr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pktgen_drr_sched : deficit-round-robin arbiter feeding one tuple stream     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module pktgen_drr_sched
  import pktgen_sched_pkg::*;
#(
  parameter int NUM_QUEUES      = 4,
  parameter int PKT_TUPLE_WIDTH = 104,
  parameter int PKT_LEN_WIDTH   = 16,
  parameter int QUANTUM_WIDTH   = 16,
  parameter int DEFICIT_WIDTH   = 18,
  parameter int QID_WIDTH       = $clog2(NUM_QUEUES)
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [NUM_QUEUES-1:0]                 q_vld,
  input  logic [NUM_QUEUES*PKT_TUPLE_WIDTH-1:0] q_tuple,
  input  logic [NUM_QUEUES*PKT_LEN_WIDTH-1:0]   q_len,
  output logic [NUM_QUEUES-1:0]                 q_ready,
  input  logic [NUM_QUEUES-1:0]                 q_enable,
  input  logic [NUM_QUEUES*QUANTUM_WIDTH-1:0]   quantum,
  output logic [PKT_TUPLE_WIDTH-1:0]            tuple_out,
  output logic [PKT_LEN_WIDTH-1:0]              pkt_len_out,
  output logic [QID_WIDTH-1:0]                  qid_out,
  output logic                                  tuple_out_vld,
  input  logic                                  tuple_out_ready,
  output logic [31:0]                           grant_cnt
);

  logic [PKT_TUPLE_WIDTH-1:0] w_tuple_arr   [NUM_QUEUES];
  logic [PKT_LEN_WIDTH-1:0]   w_len_arr     [NUM_QUEUES];
  logic [QUANTUM_WIDTH-1:0]   w_quantum_arr [NUM_QUEUES];

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_unpack
    assign w_tuple_arr[g]   = q_tuple[g*PKT_TUPLE_WIDTH +: PKT_TUPLE_WIDTH];
    assign w_len_arr[g]     = q_len[g*PKT_LEN_WIDTH +: PKT_LEN_WIDTH];
    assign w_quantum_arr[g] = quantum[g*QUANTUM_WIDTH +: QUANTUM_WIDTH];
  end

  sched_state_t               r_state, w_state_nxt;
  logic [QID_WIDTH-1:0]       r_cur, w_cur_nxt, w_cur_inc;
  logic [PKT_TUPLE_WIDTH-1:0] r_tuple;
  logic [PKT_LEN_WIDTH-1:0]   r_len;
  logic [QID_WIDTH-1:0]       r_qid;
  logic                       r_out_vld;
  logic [31:0]                r_grant_cnt;

  logic [PKT_LEN_WIDTH-1:0]   w_len_cur, w_eff_len;
  logic [QUANTUM_WIDTH-1:0]   w_quantum_cur;
  logic [DEFICIT_WIDTH-1:0]   w_def_cur, w_operand;
  logic                       w_elig, w_vld, w_fits, w_grant;
  def_op_t                    w_op;

  assign w_len_cur     = w_len_arr[r_cur];
  assign w_quantum_cur = w_quantum_arr[r_cur];
  // Runts are charged as minimum-size frames so tiny heads cannot starve others.
  assign w_eff_len     = (w_len_cur < PKT_LEN_WIDTH'(MIN_PKT_LEN)) ?
                         PKT_LEN_WIDTH'(MIN_PKT_LEN) : w_len_cur;
  assign w_elig        = q_enable[r_cur] && (w_quantum_cur != '0);
  assign w_vld         = q_vld[r_cur];
  assign w_fits        = (w_def_cur >= DEFICIT_WIDTH'(w_eff_len));
  assign w_cur_inc     = (r_cur == QID_WIDTH'(NUM_QUEUES-1)) ? '0 : r_cur + QID_WIDTH'(1);

  drr_deficit_bank #(
    .NUM_QUEUES    (NUM_QUEUES),
    .DEFICIT_WIDTH (DEFICIT_WIDTH),
    .QID_WIDTH     (QID_WIDTH)
  ) u_bank (
    .clk       (clk),
    .resetn    (resetn),
    .i_idx     (r_cur),
    .i_op      (w_op),
    .i_operand (w_operand),
    .o_deficit (w_def_cur)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_op        = DEF_NOP;
    w_operand   = '0;
    w_grant     = 1'b0;
    q_ready     = '0;
    unique case (r_state)
      ST_SCAN: begin
        if (w_elig && w_vld) begin
          w_op        = DEF_ADD;
          w_operand   = DEFICIT_WIDTH'(w_quantum_cur);
          w_state_nxt = ST_CHECK;
        end else begin
          w_op      = DEF_CLR;
          w_cur_nxt = w_cur_inc;
        end
      end
      ST_CHECK: begin
        if (w_elig && w_vld && w_fits) begin
          w_grant        = 1'b1;
          q_ready[r_cur] = 1'b1;
          w_op           = DEF_SUB;
          w_operand      = DEFICIT_WIDTH'(w_eff_len);
          w_state_nxt    = ST_OUT;
        end else begin
          // A short deficit carries into the next round; an idle queue forfeits it.
          if (!(w_elig && w_vld)) w_op = DEF_CLR;
          w_cur_nxt   = w_cur_inc;
          w_state_nxt = ST_SCAN;
        end
      end
      ST_OUT: begin
        if (tuple_out_ready) w_state_nxt = ST_CHECK;
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_SCAN;
      r_cur       <= '0;
      r_tuple     <= '0;
      r_len       <= '0;
      r_qid       <= '0;
      r_out_vld   <= 1'b0;
      r_grant_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      if (w_grant) begin
        r_tuple     <= w_tuple_arr[r_cur];
        r_len       <= w_len_cur;
        r_qid       <= r_cur;
        r_out_vld   <= 1'b1;
        r_grant_cnt <= r_grant_cnt + 32'd1;
      end else if (r_out_vld && tuple_out_ready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign tuple_out     = r_tuple;
  assign pkt_len_out   = r_len;
  assign qid_out       = r_qid;
  assign tuple_out_vld = r_out_vld;
  assign grant_cnt     = r_grant_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pktgen_drr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pktgen_drr_sched : DRR scheduler bench with transaction-level DRR model  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_pktgen_drr_sched;

  localparam int NQ   = 4;
  localparam int TW   = 104;
  localparam int LW   = 16;
  localparam int QW   = 16;
  localparam int DW   = 18;
  localparam int IW   = 2;
  localparam int DMAX = (1 << DW) - 1;

  typedef struct {
    logic [TW-1:0] tup;
    int            len;
  } pkt_t;

  typedef struct {
    int            qid;
    logic [TW-1:0] tup;
    int            len;
  } exp_t;

  logic               clk;
  logic               resetn;
  logic [NQ-1:0]      q_vld;
  logic [NQ*TW-1:0]   q_tuple;
  logic [NQ*LW-1:0]   q_len;
  logic [NQ-1:0]      q_ready;
  logic [NQ-1:0]      q_enable;
  logic [NQ*QW-1:0]   quantum;
  logic [TW-1:0]      tuple_out;
  logic [LW-1:0]      pkt_len_out;
  logic [IW-1:0]      qid_out;
  logic               tuple_out_vld;
  logic               tuple_out_ready;
  logic [31:0]        grant_cnt;

  pktgen_drr_sched dut (
    .clk             (clk),
    .resetn          (resetn),
    .q_vld           (q_vld),
    .q_tuple         (q_tuple),
    .q_len           (q_len),
    .q_ready         (q_ready),
    .q_enable        (q_enable),
    .quantum         (quantum),
    .tuple_out       (tuple_out),
    .pkt_len_out     (pkt_len_out),
    .qid_out         (qid_out),
    .tuple_out_vld   (tuple_out_vld),
    .tuple_out_ready (tuple_out_ready),
    .grant_cnt       (grant_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pkt_t          pkts [NQ][$];
  exp_t          exp_q[$];
  int            grant_cyc[$];
  int            total, bad, cyc, xfers, n_q0, n_exp, rdy_mode;
  bit            prev_hold;
  logic [TW-1:0] prev_tuple;
  logic [LW-1:0] prev_len;
  logic [IW-1:0] prev_qid;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_heads();
    for (int i = 0; i < NQ; i++) begin
      if (pkts[i].size() > 0) begin
        q_vld[i]             = 1'b1;
        q_tuple[i*TW +: TW]  = pkts[i][0].tup;
        q_len[i*LW +: LW]    = LW'(pkts[i][0].len);
      end else begin
        q_vld[i]             = 1'b0;
        q_tuple[i*TW +: TW]  = '0;
        q_len[i*LW +: LW]    = '0;
      end
    end
  endtask

  task automatic set_q(input int i, input bit en, input int qv);
    q_enable[i]           = en;
    quantum[i*QW +: QW]   = QW'(qv);
  endtask

  function automatic logic [TW-1:0] rnd_tuple();
    return {$urandom(), $urandom(), $urandom(), 8'($urandom())};
  endfunction

  task automatic add_pkt(input int i, input int len);
    pkt_t p;
    p.tup = rnd_tuple();
    p.len = len;
    pkts[i].push_back(p);
  endtask

  // Classic byte-based DRR over the preloaded queues: each visit to a backlogged,
  // eligible queue adds its quantum and sends heads while they fit.
  function automatic void drr_model();
    pkt_t work [NQ][$];
    int   def  [NQ];
    int   remaining, qv, el;
    exp_t e;
    remaining = 0;
    for (int i = 0; i < NQ; i++) begin
      work[i] = pkts[i];
      def[i]  = 0;
      if (q_enable[i] && quantum[i*QW +: QW] != 0) remaining += work[i].size();
    end
    while (remaining > 0) begin
      for (int i = 0; i < NQ; i++) begin
        qv = int'(quantum[i*QW +: QW]);
        if (q_enable[i] && qv != 0 && work[i].size() > 0) begin
          def[i] = (def[i] + qv > DMAX) ? DMAX : def[i] + qv;
          while (work[i].size() > 0) begin
            el = (work[i][0].len < 60) ? 60 : work[i][0].len;
            if (def[i] < el) break;
            e.qid = i; e.tup = work[i][0].tup; e.len = work[i][0].len;
            exp_q.push_back(e);
            def[i] -= el;
            void'(work[i].pop_front());
            remaining--;
          end
          if (work[i].size() == 0) def[i] = 0;
        end else begin
          def[i] = 0;
        end
      end
    end
  endfunction

  task automatic tick();
    logic [NQ-1:0] pop;
    exp_t          e;
    @(negedge clk);
    cyc++;
    chk("qready_onehot0", 128'($onehot0(q_ready)), 128'd1);
    if (tuple_out_vld) chk("qready_while_vld", 128'(q_ready), 128'd0);
    if (prev_hold) begin
      chk("hold_vld", 128'(tuple_out_vld), 128'd1);
      chk("hold_tuple", 128'(tuple_out), 128'(prev_tuple));
      chk("hold_len", 128'(pkt_len_out), 128'(prev_len));
      chk("hold_qid", 128'(qid_out), 128'(prev_qid));
    end
    if (tuple_out_vld && tuple_out_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        chk("extra_grant", 128'd1, 128'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_qid", 128'(qid_out), 128'(e.qid));
        chk("out_tuple", 128'(tuple_out), 128'(e.tup));
        chk("out_len", 128'(pkt_len_out), 128'(e.len));
        if (qid_out == 0) n_q0++;
      end
    end
    prev_hold  = tuple_out_vld && !tuple_out_ready && resetn;
    prev_tuple = tuple_out;
    prev_len   = pkt_len_out;
    prev_qid   = qid_out;
    pop        = q_ready;
    if (pop != '0) grant_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    for (int i = 0; i < NQ; i++) begin
      if (pop[i] && pkts[i].size() > 0) void'(pkts[i].pop_front());
    end
    drive_heads();
    if (rdy_mode == 0) tuple_out_ready = 1'b1;
    else if (rdy_mode == 1) tuple_out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic hold_reset();
    resetn          = 1'b0;
    rdy_mode        = 0;
    tuple_out_ready = 1'b1;
    for (int i = 0; i < NQ; i++) begin
      pkts[i].delete();
      set_q(i, 1'b0, 0);
    end
    exp_q.delete();
    drive_heads();
    tick();
    tick();
  endtask

  task automatic release_run(input bit use_model);
    if (use_model) drr_model();
    n_exp = exp_q.size();
    xfers = 0;
    n_q0  = 0;
    grant_cyc.delete();
    drive_heads();
    resetn = 1'b1;
  endtask

  task automatic run_until(input string tag, input int max_xfers, input int budget);
    int c;
    c = 0;
    while (exp_q.size() > 0 && xfers < max_xfers && c < budget) begin
      tick();
      c++;
    end
    chk({tag, "_timeout"}, 128'(c < budget), 128'd1);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; xfers = 0; n_q0 = 0; n_exp = 0;
    prev_hold = 1'b0; prev_tuple = '0; prev_len = '0; prev_qid = '0;
    resetn = 1'b0; rdy_mode = 0; tuple_out_ready = 1'b1;
    q_vld = '0; q_tuple = '0; q_len = '0; q_enable = '0; quantum = '0;

    // Reset state
    hold_reset();
    chk("rst_vld", 128'(tuple_out_vld), 128'd0);
    chk("rst_tuple", 128'(tuple_out), 128'd0);
    chk("rst_len", 128'(pkt_len_out), 128'd0);
    chk("rst_qid", 128'(qid_out), 128'd0);
    chk("rst_gcnt", 128'(grant_cnt), 128'd0);
    chk("rst_qready", 128'(q_ready), 128'd0);
    for (int i = 0; i < NQ; i++) chk("rst_deficit", 128'(dut.u_bank.r_deficit[i]), 128'd0);

    // Single queue: three back-to-back grants, a rescan, then the fourth
    hold_reset();
    set_q(0, 1'b1, 1500);
    for (int k = 0; k < 4; k++) add_pkt(0, 500);
    release_run(1'b1);
    run_until("single", 1000, 200);
    chk("single_gcnt", 128'(grant_cnt), 128'd4);
    chk("single_ngrants", 128'(grant_cyc.size()), 128'd4);
    if (grant_cyc.size() == 4) begin
      chk("single_gap1", 128'(grant_cyc[1] - grant_cyc[0]), 128'd2);
      chk("single_gap2", 128'(grant_cyc[2] - grant_cyc[1]), 128'd2);
      chk("single_gap3", 128'(grant_cyc[3] - grant_cyc[2]), 128'd7);
    end

    // Minimum-length accounting
    hold_reset();
    set_q(2, 1'b1, 60);
    add_pkt(2, 20);
    release_run(1'b1);
    run_until("minlen", 1000, 100);
    chk("minlen_deficit", 128'(dut.u_bank.r_deficit[2]), 128'd0);
    chk("minlen_gcnt", 128'(grant_cnt), 128'd1);

    // Weighted share 3:1
    hold_reset();
    set_q(0, 1'b1, 3000);
    set_q(1, 1'b1, 1000);
    for (int k = 0; k < 400; k++) begin
      add_pkt(0, 1000);
      add_pkt(1, 1000);
    end
    release_run(1'b1);
    run_until("weighted", 400, 5000);
    chk("weighted_xfers", 128'(xfers), 128'd400);
    chk("weighted_ratio", 128'(n_q0 >= 299 && n_q0 <= 301), 128'd1);

    // Backpressure: ten stalled cycles after a grant
    hold_reset();
    set_q(0, 1'b1, 1500);
    for (int k = 0; k < 3; k++) add_pkt(0, 500);
    rdy_mode = 2;
    tuple_out_ready = 1'b0;
    release_run(1'b1);
    begin
      int c;
      int xb;
      c = 0;
      while (!tuple_out_vld && c < 20) begin tick(); c++; end
      chk("bp_vld_timeout", 128'(c < 20), 128'd1);
      xb = xfers;
      for (int k = 0; k < 10; k++) begin
        tick();
        chk("bp_no_qready", 128'(q_ready), 128'd0);
      end
      chk("bp_no_xfer", 128'(xfers), 128'(xb));
      tuple_out_ready = 1'b1;
      tick();
      chk("bp_first_ready_xfer", 128'(xfers), 128'(xb + 1));
    end
    rdy_mode = 0;
    run_until("bp", 1000, 200);
    chk("bp_gcnt", 128'(grant_cnt), 128'd3);

    // Disable: deficit 700 carried, then forfeited once the queue is disabled
    hold_reset();
    set_q(1, 1'b1, 1000);
    add_pkt(1, 300);
    add_pkt(1, 1500);
    begin
      exp_t e;
      e.qid = 1; e.tup = pkts[1][0].tup; e.len = 300;
      exp_q.push_back(e);
    end
    release_run(1'b0);
    begin
      int c;
      c = 0;
      while (xfers < 1 && c < 50) begin tick(); c++; end
      chk("dis_timeout", 128'(c < 50), 128'd1);
    end
    tick();
    chk("dis_deficit_kept", 128'(dut.u_bank.r_deficit[1]), 128'd700);
    q_enable[1] = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("dis_deficit_cleared", 128'(dut.u_bank.r_deficit[1]), 128'd0);
    chk("dis_no_grant", 128'(grant_cnt), 128'd1);
    chk("dis_xfers", 128'(xfers), 128'd1);

    // Randomized configurations against the DRR model
    for (int s = 0; s < 4; s++) begin
      hold_reset();
      for (int i = 0; i < NQ; i++) begin
        set_q(i, ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(64, 3000)));
        for (int k = 0; k < int'($urandom_range(0, 8)); k++)
          add_pkt(i, int'($urandom_range(1, 1600)));
      end
      rdy_mode = 1;
      release_run(1'b1);
      run_until("rand", 100000, 30000);
      for (int k = 0; k < 4; k++) tick();
      chk("rand_gcnt", 128'(grant_cnt), 128'(n_exp));
    end

    // Reset while a tuple is held in OUT
    hold_reset();
    set_q(0, 1'b1, 1500);
    add_pkt(0, 500);
    add_pkt(0, 500);
    rdy_mode = 2;
    tuple_out_ready = 1'b0;
    release_run(1'b1);
    begin
      int c;
      c = 0;
      while (!tuple_out_vld && c < 20) begin tick(); c++; end
      chk("rstout_vld_timeout", 128'(c < 20), 128'd1);
    end
    resetn = 1'b0;
    tick();
    chk("rstout_vld", 128'(tuple_out_vld), 128'd0);
    chk("rstout_gcnt", 128'(grant_cnt), 128'd0);
    chk("rstout_cur", 128'(dut.r_cur), 128'd0);
    for (int i = 0; i < NQ; i++) chk("rstout_deficit", 128'(dut.u_bank.r_deficit[i]), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
